// File: rtl/decred_result_collector.sv
// Collects 4-byte nonce results from the hash macros over the shared read bus,
// servicing pending macros round-robin and queueing {macro, nonce} in a small FIFO.
module decred_result_collector #(
    parameter int         NUM_MACROS       = 4,
    parameter logic [5:0] RESULT_BASE_ADDR = 6'h38,
    parameter int         FIFO_DEPTH       = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  HASH_EN,
    input  logic [NUM_MACROS-1:0] DATA_AVAILABLE,
    input  logic [7:0]            DATA_FROM_HASH,
    input  logic                  BUS_GRANT,
    output logic                  BUS_REQ,
    output logic [NUM_MACROS-1:0] MACRO_RD_SELECT,
    output logic [5:0]            HASH_ADDR,
    output logic                  RESULT_VALID,
    input  logic                  RESULT_READY,
    output logic [31:0]           RESULT_DATA,
    output logic [1:0]            RESULT_MACRO,
    output logic [2:0]            FIFO_LEVEL,
    output logic                  BUSY
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, READ, PUSH} state_t;
    typedef struct packed {
        logic [1:0]  macro;
        logic [31:0] nonce;
    } result_t;

    state_t                state, state_nxt;
    logic [2:0]            k;
    logic [1:0]            sel, ptr, pick, idx;
    logic                  pick_vld, start, full, push, pop, arm_clr;
    logic [31:0]           nonce;
    logic [NUM_MACROS-1:0] armed, pending;
    result_t               fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;

    assign pending = DATA_AVAILABLE & armed;
    assign full    = (FIFO_LEVEL == 3'(FIFO_DEPTH));
    assign arm_clr = (state == READ) && (k == 3'd4);

    // Round-robin: scan downward so the lowest offset from ptr wins last.
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = NUM_MACROS - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (pending[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        start           = 1'b0;
        BUS_REQ         = 1'b0;
        MACRO_RD_SELECT = '0;
        HASH_ADDR       = '0;
        case (state)
            IDLE: begin
                if (HASH_EN && pick_vld && !full) begin
                    state_nxt = WAIT_GNT;
                    start     = 1'b1;
                end
            end
            WAIT_GNT: begin
                BUS_REQ = 1'b1;
                if (!HASH_EN)       state_nxt = IDLE;
                else if (BUS_GRANT) state_nxt = READ;
            end
            READ: begin
                BUS_REQ = 1'b1;
                if (k < 3'd4) begin
                    MACRO_RD_SELECT = NUM_MACROS'(1) << sel;
                    HASH_ADDR       = RESULT_BASE_ADDR + {3'b000, k};
                end else begin
                    state_nxt = PUSH;
                end
            end
            PUSH:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign BUSY = (state != IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            k     <= '0;
            sel   <= '0;
            ptr   <= '0;
            nonce <= '0;
            armed <= '1;
        end else begin
            state <= state_nxt;
            if (start) sel <= pick;
            k <= (state == READ) ? k + 3'd1 : 3'd0;
            // Read data trails the address by one cycle, so byte k arrives at k+1.
            if (state == READ) begin
                case (k)
                    3'd1:    nonce[7:0]   <= DATA_FROM_HASH;
                    3'd2:    nonce[15:8]  <= DATA_FROM_HASH;
                    3'd3:    nonce[23:16] <= DATA_FROM_HASH;
                    3'd4:    nonce[31:24] <= DATA_FROM_HASH;
                    default: ;
                endcase
            end
            if (state == PUSH) ptr <= sel + 2'd1;
            for (int m = 0; m < NUM_MACROS; m++) begin
                if (arm_clr && sel == 2'(m))   armed[m] <= 1'b0;
                else if (!DATA_AVAILABLE[m])   armed[m] <= 1'b1;
            end
        end
    end

    assign push         = (state == PUSH);
    assign RESULT_VALID = (FIFO_LEVEL != 3'd0);
    assign pop          = RESULT_VALID & RESULT_READY;
    assign RESULT_DATA  = fifo_mem[rd_ptr].nonce;
    assign RESULT_MACRO = fifo_mem[rd_ptr].macro;

    // Space was checked before leaving IDLE, so a push never finds the FIFO full.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{macro: sel, nonce: nonce};
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   FIFO_LEVEL <= FIFO_LEVEL + 3'd1;
                2'b01:   FIFO_LEVEL <= FIFO_LEVEL - 3'd1;
                default: ;
            endcase
        end
    end
endmodule
